// File: rtl/fcb_bitstream_loader.sv
// fcb_bitstream_loader
// Streams a bitstream from a valid/ready source into the FPGA configuration
// block over a single-cycle Wishbone-style master (no ack). Writes length,
// checksum and control, then one data word per FCB word-completion, and can
// optionally run the FCB readback/Adler-32 verify before reporting.
module fcb_bitstream_loader #(
   parameter int FIFO_DEPTH  = 4,
   parameter int GUARD_CYC   = 4,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] bit_length,
   input  logic [31:0] exp_checksum,
   input  logic        verify_en,
   input  logic [31:0] s_word,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [2:0]  wb_address,
   output logic [31:0] wb_data_out,
   output logic [3:0]  wb_select,
   output logic        wb_stb,
   output logic        wb_we,
   output logic        wb_bus_cycle,
   input  logic [31:0] wb_data_in,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [1:0]  err_code
);

   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int CNT_MAX = (TIMEOUT_CYC > GUARD_CYC) ? TIMEOUT_CYC : GUARD_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);
   localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYC - 1);

   // FCB register map
   localparam logic [2:0] ADDR_CTRL  = 3'd0;
   localparam logic [2:0] ADDR_WRITE = 3'd1;
   localparam logic [2:0] ADDR_LEN   = 3'd2;
   localparam logic [2:0] ADDR_CHK   = 3'd3;
   localparam logic [2:0] ADDR_STAT  = 3'd4;

   // Control register values
   localparam logic [31:0] CTRL_OFF  = 32'h0;
   localparam logic [31:0] CTRL_LOAD = 32'h1;
   localparam logic [31:0] CTRL_RB   = 32'h2;

   // Completion codes
   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_ZERO    = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_CHK     = 2'd3;

   typedef enum logic [3:0] {
      S_IDLE, S_WR_LEN, S_WR_CHK, S_WR_CTRL, S_WAIT_FIFO, S_WR_DATA, S_GUARD,
      S_POLL_W, S_LOAD_END, S_WR_RB, S_POLL_V, S_CLR, S_FIN
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [31:0]     r_chk;
   logic            r_verify;
   logic            r_res_pass;
   logic [1:0]      r_res_err;
   logic            r_stb;
   logic            r_we;
   logic [2:0]      r_addr;
   logic [31:0]     r_wdata;
   logic            r_busy;
   logic            r_done;
   logic            r_pass;
   logic [1:0]      r_err;

   // Stream buffer
   logic [31:0]     r_mem [FIFO_DEPTH];
   logic [AW:0]     r_wr_ptr;
   logic [AW:0]     r_rd_ptr;
   logic            w_full;
   logic            w_empty;
   logic            w_push;
   logic            w_pop;
   logic            w_flush;
   logic [31:0]     w_head;
   logic [3:0]      w_status;
   logic            w_unused;

   assign w_empty  = (r_wr_ptr == r_rd_ptr);
   assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push   = s_valid && !w_full;
   assign w_pop    = (r_state == S_WR_DATA);
   assign w_flush  = (r_state == S_FIN);
   assign w_head   = r_mem[r_rd_ptr[AW-1:0]];
   assign w_status = wb_data_in[3:0];
   assign w_unused = &{1'b0, wb_data_in[31:4]};

   assign s_ready      = !w_full;
   assign wb_stb       = r_stb;
   assign wb_bus_cycle = r_stb;
   assign wb_we        = r_we;
   assign wb_address   = r_addr;
   assign wb_data_out  = r_wdata;
   assign wb_select    = r_stb ? 4'hF : 4'h0;
   assign busy         = r_busy;
   assign done         = r_done;
   assign pass         = r_pass;
   assign err_code     = r_err;

   // Buffer storage write on every accepted stream beat.
   // NOTE: the storage array is not reset; the pointers alone say which entries are valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= s_word;
   end

   // Buffer pointers: push on handshake, pop in the data-write cycle, flush at completion.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Load sequencer: bus strobes are registered on entry to each access state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_chk      <= '0;
         r_verify   <= 1'b0;
         r_res_pass <= 1'b0;
         r_res_err  <= ERR_NONE;
         r_stb      <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_err      <= ERR_NONE;
      end else begin
         // NOTE: defaults first, so every access and the done pulse last exactly one cycle
         // unless a branch below re-asserts them.
         r_stb   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_err   <= ERR_NONE;
         if (r_cnt != {CW{1'b1}}) r_cnt <= r_cnt + 1'b1;

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_busy     <= 1'b1;
                  r_chk      <= exp_checksum;
                  r_verify   <= verify_en;
                  r_res_pass <= 1'b0;
                  r_cnt      <= '0;
                  if (bit_length == '0) begin
                     r_res_err <= ERR_ZERO;
                     r_state   <= S_FIN;
                  end else begin
                     r_res_err <= ERR_NONE;
                     r_state   <= S_WR_LEN;
                     r_stb     <= 1'b1;
                     r_we      <= 1'b1;
                     r_addr    <= ADDR_LEN;
                     r_wdata   <= bit_length;
                  end
               end
            end
            S_WR_LEN: begin
               r_state <= S_WR_CHK;
               r_cnt   <= '0;
               r_stb   <= 1'b1;
               r_we    <= 1'b1;
               r_addr  <= ADDR_CHK;
               r_wdata <= r_chk;
            end
            S_WR_CHK: begin
               r_state <= S_WR_CTRL;
               r_cnt   <= '0;
               r_stb   <= 1'b1;
               r_we    <= 1'b1;
               r_addr  <= ADDR_CTRL;
               r_wdata <= CTRL_LOAD;
            end
            S_WR_CTRL: begin
               r_state <= S_WAIT_FIFO;
               r_cnt   <= '0;
            end
            S_WAIT_FIFO: begin
               // Source starvation is legal; wait here without a timeout.
               if (!w_empty) begin
                  r_state <= S_WR_DATA;
                  r_cnt   <= '0;
                  r_stb   <= 1'b1;
                  r_we    <= 1'b1;
                  r_addr  <= ADDR_WRITE;
                  r_wdata <= w_head;
               end
            end
            S_WR_DATA: begin
               r_state <= S_GUARD;
               r_cnt   <= '0;
            end
            S_GUARD: begin
               if (r_cnt == GUARD_LAST) begin
                  r_state <= S_POLL_W;
                  r_cnt   <= '0;
                  r_stb   <= 1'b1;
                  r_addr  <= ADDR_STAT;
               end
            end
            S_POLL_W: begin
               // Load-complete outranks word-complete.
               if (w_status[1]) begin
                  r_state <= S_LOAD_END;
                  r_cnt   <= '0;
                  r_stb   <= 1'b1;
                  r_we    <= 1'b1;
                  r_addr  <= ADDR_CTRL;
                  r_wdata <= CTRL_OFF;
               end else if (w_status[0]) begin
                  r_state <= S_WAIT_FIFO;
                  r_cnt   <= '0;
               end else if (r_cnt == TMO_LAST) begin
                  r_res_err <= ERR_TIMEOUT;
                  r_state   <= S_FIN;
                  r_cnt     <= '0;
               end else begin
                  r_stb  <= 1'b1;
                  r_addr <= ADDR_STAT;
               end
            end
            S_LOAD_END: begin
               r_cnt <= '0;
               if (!r_verify) begin
                  r_res_pass <= 1'b1;
                  r_state    <= S_FIN;
               end else begin
                  r_state <= S_WR_RB;
                  r_stb   <= 1'b1;
                  r_we    <= 1'b1;
                  r_addr  <= ADDR_CTRL;
                  r_wdata <= CTRL_RB;
               end
            end
            S_WR_RB: begin
               r_state <= S_POLL_V;
               r_cnt   <= '0;
               r_stb   <= 1'b1;
               r_addr  <= ADDR_STAT;
            end
            S_POLL_V: begin
               if (w_status[2] || w_status[3] || (r_cnt == TMO_LAST)) begin
                  if (w_status[2])      r_res_pass <= 1'b1;
                  else if (w_status[3]) r_res_err  <= ERR_CHK;
                  else                  r_res_err  <= ERR_TIMEOUT;
                  r_state <= S_CLR;
                  r_cnt   <= '0;
                  r_stb   <= 1'b1;
                  r_we    <= 1'b1;
                  r_addr  <= ADDR_CTRL;
                  r_wdata <= CTRL_OFF;
               end else begin
                  r_stb  <= 1'b1;
                  r_addr <= ADDR_STAT;
               end
            end
            S_CLR: begin
               r_state <= S_FIN;
               r_cnt   <= '0;
            end
            S_FIN: begin
               r_done  <= 1'b1;
               r_pass  <= r_res_pass;
               r_err   <= r_res_err;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/fcb_bitstream_loader.md
Name: fcb_bitstream_loader

Overview:
- Wishbone master that sits directly upstream of the FPGA configuration block (FCB) slave.
- Accepts bitstream words on a valid/ready stream, buffers them in a small FIFO and programs the FCB: length, checksum, control, then one data word per FCB word-completion.
- Optionally runs FCB readback/Adler-32 verify and reports pass/fail, removing per-word software polling.

Parameters:
- FIFO_DEPTH, 4, stream buffer depth in 32-bit words (power of 2, >=2).
- GUARD_CYC, 4, idle cycles after each data write before the first status poll.
- TIMEOUT_CYC, 65535, max poll cycles per wait before error.

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- bit_length  in  32  bitstream length in bits; sampled on start
- exp_checksum  in  32  expected Adler-32; sampled on start
- verify_en  in  1  run readback verify after load; sampled on start
- s_word  in  32  bitstream word, MSB shifted first
- s_valid  in  1  s_word valid
- s_ready  out  1  FIFO not full
- wb_address  out  3  FCB register index (0 ctrl, 1 write, 2 length, 3 checksum, 4 status)
- wb_data_out  out  32  write data to FCB
- wb_select  out  4  byte enables; always 4'hF during an access
- wb_stb  out  1  access strobe
- wb_we  out  1  write enable
- wb_bus_cycle  out  1  bus cycle; equal to wb_stb
- wb_data_in  in  32  read data from FCB (combinational, same cycle)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- pass  out  1  valid with done: load ok and (verify off or checksum match)
- err_code  out  2  valid with done: 0 none, 1 zero length, 2 timeout, 3 checksum mismatch

Behaviour:
- Reset: every output 0 except s_ready = 1. FIFO emptied, counters 0, FSM in IDLE. Applies asynchronously mid-operation; the FCB is not cleaned up.
- Access protocol (no ack):
  - Every FCB access is exactly one cycle with wb_stb = wb_bus_cycle = 1 and wb_select = F.
  - Reads sample wb_data_in at the posedge ending that cycle.
  - wb_stb is low in all other cycles.
- FIFO:
  - A push happens when s_valid & s_ready.
  - A pop happens only in the WR_DATA cycle.
  - Simultaneous push/pop while full is not possible, because s_ready = !full.
  - The FIFO flushes to empty when done fires.
- FSM:
  - IDLE: on start, latch inputs and raise busy. bit_length == 0 -> FIN with err 1. Otherwise WR_LEN.
  - WR_LEN: write addr 2 = bit_length -> WR_CHK.
  - WR_CHK: write addr 3 = exp_checksum -> WR_CTRL.
  - WR_CTRL: write addr 0 = 32'h1 -> WAIT_FIFO.
  - WAIT_FIFO: FIFO non-empty -> WR_DATA. Stall indefinitely, with no timeout.
  - WR_DATA: write addr 1 = FIFO head, pop -> GUARD.
  - GUARD: count GUARD_CYC cycles -> POLL_W.
  - POLL_W: read addr 4 every cycle.
    - Bit1 set -> LOAD_END (takes priority over bit0).
    - Else bit0 set -> WAIT_FIFO.
    - TIMEOUT_CYC polls without either bit -> FIN, err 2.
  - LOAD_END: write addr 0 = 0 -> FIN with pass if !verify_en, else WR_RB.
  - WR_RB: write addr 0 = 32'h2 -> POLL_V.
  - POLL_V: read addr 4.
    - Bit2 set -> CLR with pass.
    - Bit3 set -> CLR, err 3.
    - Timeout -> CLR, err 2.
  - CLR: write addr 0 = 0 -> FIN.
  - FIN: pulse done with pass/err_code, clear busy -> IDLE.
- Surplus FIFO words after bitstream completion are discarded by the flush.
- The timeout counter resets on every state entry and saturates.
- start while busy is ignored.

Test Plan:
- Load 64 bits, verify_en = 0, two words A5A5A5A5 and 0F0F0F0F streamed; FCB model sets status bit0 after each word and bit1 after the second -> bus trace is len=64, chk, ctrl=1, w1, w2, ctrl=0; done with pass=1, err=0.
- bit_length = 0 -> no bus activity; done on the 2nd cycle after start, pass=0, err=1.
- Stream starved for 200 cycles between words -> no timeout; wb_stb stays low; load completes pass=1.
- FCB model never asserts status bits -> done after TIMEOUT_CYC polls, err=2, last write is none (no cleanup).
- verify_en = 1, model returns bit3 -> writes ctrl=2, ctrl=0; done pass=0, err=3. With bit2 instead -> pass=1.
- FIFO_DEPTH words pushed with the FCB stalled -> s_ready drops to 0. Reset asserted mid-WR_DATA -> all outputs 0 immediately, s_ready = 1.
